mcu_target_router: RTL
======================

# mcu_target_router

Byte-level front end between the MCU link byte layer and the per-function command endpoints (system control, HID, OSD, SD card). The first byte of every frame selects a target. All following bytes are forwarded to that target, and the target's reply byte is returned to the MCU. The block also merges the endpoints' interrupt lines into the single active-low MCU interrupt, applies a mask, and aborts stalled frames with a watchdog.

## Interface
- `TARGETS`, default 4: number of endpoints, 1..8.
- `TIMEOUT`, default 2_000_000: idle clocks inside a frame before it is aborted. Must be ≥ 2.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `in_strobe` input 1: one-cycle pulse, byte valid from the link.
- `in_start` input 1: qualifies `in_strobe`; marks the first byte of a frame.
- `in_data` input 8: byte from the MCU.
- `out_data` output 8: reply byte to the MCU (registered).
- `tgt_strobe` output TARGETS: one-hot forward strobe, registered.
- `tgt_start` output 1: forwarded byte is the command byte.
- `tgt_data` output 8: forwarded byte.
- `tgt_dout` input 8*TARGETS: reply bytes; target n occupies bits [8n+7:8n].
- `tgt_irq` input TARGETS: level interrupt requests.
- `int_out_n` output 1: merged interrupt to the MCU, active-low, registered.
- `frame_error` output 1: one-cycle pulse when a frame is aborted by timeout.

## Operation
- **Reset values:**
  - state IDLE.
  - `out_data`=0x00; `tgt_strobe`=0, `tgt_start`=0, `tgt_data`=0x00.
  - `int_out_n`=1, `frame_error`=0.
  - `irq_mask`=all ones; `abort_cnt`=0; `sel`=0x00.
- **States:** IDLE, CMD (waiting for the command byte), DATA (payload).
- **`in_strobe` with `in_start`:** valid in any state; overrides a pending timeout in the same cycle.
  - `sel` <= `in_data`.
  - state <= CMD.
  - `out_data` <= {pending[7:0]}, where pending = `tgt_irq & irq_mask`, zero-extended to 8 bits.
  - Nothing is forwarded.
- **`in_strobe` without `in_start` in CMD:**
  - If `sel` < TARGETS: `tgt_strobe[sel]`=1, `tgt_start`=1, `tgt_data`=`in_data`.
  - state <= DATA.
- **`in_strobe` without `in_start` in DATA:** same forward, with `tgt_start`=0.
- **`in_strobe` without `in_start` in IDLE:** ignored; `out_data` is unchanged.
- **Router control target, `sel`=0xFE:** never forwarded.
  - The command byte is latched as `rcmd`.
  - `rcmd`=0x01: the first payload byte is written to `irq_mask[TARGETS-1:0]`; later payload bytes are ignored.
  - `rcmd`=0x02: replies carry `abort_cnt`.
  - Any other `rcmd`: replies are 0x00.
- **Unknown target** (`sel` ≥ TARGETS and ≠ 0xFE): bytes are swallowed and `out_data`=0xFF.
- **Reply path, state CMD/DATA:**
  - `out_data` <= `tgt_dout[sel]` every clock for a valid target.
  - For 0xFE, `out_data` <= the control reply.
  - For an unknown target, `out_data` <= 0xFF.
- **Watchdog:**
  - A counter is reloaded with TIMEOUT on every `in_strobe` and in IDLE.
  - In CMD/DATA it decrements while there is no strobe.
  - On reaching 1: state <= IDLE, `frame_error` pulses, `abort_cnt` increments (saturating at 0xFF).
- **Interrupts:** `int_out_n` <= ~|(`tgt_irq & irq_mask`), updated every clock in all states.

## Timing
- **Forward latency:** `tgt_*` are asserted in the clock after `in_strobe` and stay high for exactly one cycle.
- **Reply latency:** `out_data` follows `tgt_dout[sel]` with 1 clock of latency. Targets register their reply on their strobe, so the byte is valid 2 clocks after the strobe. The link layer must not sample earlier than that, which the SPI byte period guarantees.
- **Interrupt latency:** `tgt_irq` to `int_out_n` is 1 clock.
- **Watchdog boundaries:**
  - A frame aborts exactly TIMEOUT-1 clocks after its last strobe.
  - A strobe on the abort cycle wins and the frame continues.
- **Reset mid-frame:** all outputs return to their reset values on the next edge; no partial strobe is emitted.
- **`sel` width:** all 8 bits are compared; 0xFE is checked before the range check.

## Structure
- **Shared package `mcu_link_pkg`:**
  - target ids: SYS=0, HID=1, OSD=2, SDC=3.
  - `ROUTER_ID`=8'hFE, `UNKNOWN_REPLY`=8'hFF.
  - router command codes: `RCMD_IRQ_MASK`=0x01, `RCMD_ABORTS`=0x02.
  - state enum.
- **Sub-module:** one natural sub-module, `frame_watchdog`, holding the reload/decrement counter and the abort pulse.
- The reply mux and the FSM live in the top level.

## Test plan
- **Normal frame:** strobes {start 0x00}, 0x04, 'R', 0x00 → `tgt_strobe`=0001 three times; first forward has `tgt_start`=1, `tgt_data`=0x04; then 0x52, then 0x00.
- **Reply path:** `tgt_dout[2]`=0xA5 with frame to target 2 → `out_data`=0xA5 one clock after `sel` is latched; after the start byte, `out_data`=pending vector.
- **Unknown target:** frame to 0x07 with TARGETS=4 → no `tgt_strobe`; `out_data`=0xFF throughout.
- **Mask control:** frame 0xFE, 0x01, 0x02 → mask=0010; `tgt_irq`=0101 gives `int_out_n`=1; `tgt_irq`=0010 gives `int_out_n`=0 after 1 clock.
- **Watchdog:** TIMEOUT=10, start plus command then silence → `frame_error` pulse 9 clocks after the last strobe; state IDLE; frame 0xFE, 0x02 then reads `out_data`=0x01.
- **Restart priority:** `in_start` strobe while in DATA on the timeout cycle → no `frame_error`; new `sel` latched; reset asserted mid-frame → all outputs at reset values next clock.

Source files
------------

// File: rtl/mcu_link_pkg.sv
// Shared definitions for the MCU link byte layer and its endpoints.
// Target ids, router control codes and the router frame state.
package mcu_link_pkg;

   localparam logic [7:0] TGT_SYS = 8'd0;
   localparam logic [7:0] TGT_HID = 8'd1;
   localparam logic [7:0] TGT_OSD = 8'd2;
   localparam logic [7:0] TGT_SDC = 8'd3;

   localparam logic [7:0] ROUTER_ID     = 8'hFE;
   localparam logic [7:0] UNKNOWN_REPLY = 8'hFF;

   localparam logic [7:0] RCMD_IRQ_MASK = 8'h01;
   localparam logic [7:0] RCMD_ABORTS   = 8'h02;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA
   } rstate_e;

endpackage

// File: rtl/frame_watchdog.sv
// Frame stall watchdog: reloads on every byte or while idle,
// counts down inside a frame and flags the abort edge.
module frame_watchdog #(
   parameter int TIMEOUT = 2_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_active,
   input  logic i_strobe,
   output logic o_abort,
   output logic o_frame_error
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_cnt;
   logic          r_frame_error;

   // Abort when this edge would bring the count down to 1.
   assign o_abort       = i_active && !i_strobe && (r_cnt == CW'(2));
   assign o_frame_error = r_frame_error;

   // Reload on activity or idle, otherwise count down; register the pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt         <= CW'(TIMEOUT);
         r_frame_error <= 1'b0;
      end else begin
         r_frame_error <= o_abort;
         if (!i_active || i_strobe || o_abort)
            r_cnt <= CW'(TIMEOUT);
         else
            r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/mcu_target_router.sv
// Routes MCU link frames to command endpoints and returns replies.
// Also merges masked endpoint interrupts into one active-low line.
module mcu_target_router
   import mcu_link_pkg::*;
#(
   parameter int TARGETS = 4,
   parameter int TIMEOUT = 2_000_000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_strobe,
   input  logic                   in_start,
   input  logic [7:0]             in_data,
   output logic [7:0]             out_data,
   output logic [TARGETS-1:0]     tgt_strobe,
   output logic                   tgt_start,
   output logic [7:0]             tgt_data,
   input  logic [8*TARGETS-1:0]   tgt_dout,
   input  logic [TARGETS-1:0]     tgt_irq,
   output logic                   int_out_n,
   output logic                   frame_error
);

   rstate_e            r_state;
   logic [7:0]         r_sel;
   logic [7:0]         r_rcmd;
   logic               r_mask_pend;
   logic [TARGETS-1:0] r_irq_mask;
   logic [7:0]         r_abort_cnt;
   logic [7:0]         r_out_data;
   logic [TARGETS-1:0] r_tgt_strobe;
   logic               r_tgt_start;
   logic [7:0]         r_tgt_data;
   logic               r_int_n;

   logic               w_active;
   logic               w_abort;
   logic               w_is_router;
   logic               w_is_valid;
   logic [TARGETS-1:0] w_pending;
   logic [TARGETS-1:0] w_onehot;
   logic [7:0]         w_pend8;
   logic [7:0]         w_tgt_reply;
   logic [7:0]         w_ctl_reply;
   logic [7:0]         w_reply;

   assign w_active    = (r_state != ST_IDLE);
   assign w_pending   = tgt_irq & r_irq_mask;
   assign w_is_router = (r_sel == ROUTER_ID);
   assign w_is_valid  = !w_is_router && (r_sel < 8'(TARGETS));
   assign w_ctl_reply = (r_rcmd == RCMD_ABORTS) ? r_abort_cnt : 8'h00;
   assign w_reply     = w_is_router ? w_ctl_reply :
                        w_is_valid  ? w_tgt_reply : UNKNOWN_REPLY;

   assign out_data   = r_out_data;
   assign tgt_strobe = r_tgt_strobe;
   assign tgt_start  = r_tgt_start;
   assign tgt_data   = r_tgt_data;
   assign int_out_n  = r_int_n;

   // Decode the selected endpoint: reply byte, strobe one-hot, pending byte.
   always_comb begin
      w_tgt_reply = 8'h00;
      w_onehot    = '0;
      w_pend8     = 8'h00;
      for (int i = 0; i < TARGETS; i++) begin
         w_pend8[i] = w_pending[i];
         if (r_sel == 8'(i)) begin
            w_tgt_reply = tgt_dout[8*i +: 8];
            w_onehot[i] = 1'b1;
         end
      end
   end

   frame_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk           (clk),
      .reset         (reset),
      .i_active      (w_active),
      .i_strobe      (in_strobe),
      .o_abort       (w_abort),
      .o_frame_error (frame_error)
   );

   // Frame FSM with forward strobes, reply register and control target.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_sel        <= 8'h00;
         r_rcmd       <= 8'h00;
         r_mask_pend  <= 1'b0;
         r_irq_mask   <= '1;
         r_abort_cnt  <= 8'h00;
         r_out_data   <= 8'h00;
         r_tgt_strobe <= '0;
         r_tgt_start  <= 1'b0;
         r_tgt_data   <= 8'h00;
         r_int_n      <= 1'b1;
      end else begin
         r_tgt_strobe <= '0;
         r_tgt_start  <= 1'b0;
         r_int_n      <= ~|w_pending;
         if (in_strobe && in_start) begin
            r_sel       <= in_data;
            r_rcmd      <= 8'h00;
            r_mask_pend <= 1'b0;
            r_state     <= ST_CMD;
            r_out_data  <= w_pend8;
         end else if (w_active) begin
            r_out_data <= w_reply;
            if (w_abort) begin
               r_state <= ST_IDLE;
               if (r_abort_cnt != 8'hFF)
                  r_abort_cnt <= r_abort_cnt + 8'd1;
            end else if (in_strobe) begin
               r_state <= ST_DATA;
               if (w_is_router) begin
                  if (r_state == ST_CMD) begin
                     r_rcmd      <= in_data;
                     r_mask_pend <= (in_data == RCMD_IRQ_MASK);
                  end else if (r_mask_pend) begin
                     r_irq_mask  <= in_data[TARGETS-1:0];
                     r_mask_pend <= 1'b0;
                  end
               end else if (w_is_valid) begin
                  r_tgt_strobe <= w_onehot;
                  r_tgt_start  <= (r_state == ST_CMD);
                  r_tgt_data   <= in_data;
               end
            end
         end
      end
   end

endmodule
